// File: rtl/pix_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pix_wr_ctrl
//  Description : Camera-side frame-buffer write master. Buffers the 24-bit
//                capture pixel stream in a small first-word-fall-through FIFO
//                and issues one single-word Avalon write per stored pixel at
//                sequential word addresses starting at BASE_ADDR.
//  Ports       :
//    clk            system / pixel clock
//    reset          synchronous, active-high reset
//    frame_start    one-cycle pulse marking the start of a camera frame
//    pix_valid      pix_data valid this cycle
//    pix_data       RGB888 pixel
//    ram_rdy        memory calibrated and ready
//    avl_ready      Avalon port accepts the current request
//    avl_write_req  Avalon write request (registered)
//    avl_addr       Avalon word address (registered)
//    wr_data        write data {8'h00, pixel} (registered)
//    busy           high whenever the controller is not IDLE
//    frame_done     one-cycle pulse when the frame is fully written
//    overflow       sticky: a pixel was dropped during this frame
//    sync_err       sticky: frame_start arrived while not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module pix_wr_ctrl #(
    parameter int unsigned FRAME_PIXELS = 307200,
    parameter logic [28:0] BASE_ADDR    = 29'd0,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    input  logic        ram_rdy,
    input  logic        avl_ready,
    output logic        avl_write_req,
    output logic [28:0] avl_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow,
    output logic        sync_err
);

    localparam int unsigned       c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]  c_DEPTH   = FIFO_DEPTH[c_PTR_W:0];
    localparam logic [c_PTR_W:0]  c_CNT_ONE = {{c_PTR_W{1'b0}}, 1'b1};
    localparam logic [28:0]       c_FRAME   = FRAME_PIXELS[28:0];

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [23:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [28:0]        r_in_cnt;
    logic               r_req;
    logic [28:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_frame_done;
    logic               r_overflow;
    logic               r_sync_err;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic               w_start;
    logic               w_xfer;
    logic               w_pix_in;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic [c_PTR_W:0]   w_count_next;
    logic               w_slot_free;
    logic               w_sel;
    logic               w_src_in_fifo;
    logic [c_PTR_W-1:0] w_rd_idx;
    logic               w_load;
    logic [23:0]        w_load_pix;
    logic               w_req_next;
    logic [28:0]        w_in_cnt_inc;
    logic [1:0]         w_state_next;

    assign w_start  = (r_state == c_IDLE) && frame_start && ram_rdy;
    assign w_xfer   = r_req && avl_ready;
    assign w_pix_in = (r_state == c_CAPTURE) && pix_valid;
    assign w_full   = (r_count == c_DEPTH);

    // A full FIFO still accepts a pixel when the head leaves on the same edge.
    assign w_push   = w_pix_in && (!w_full || w_xfer);
    assign w_drop   = w_pix_in && w_full && !w_xfer;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_xfer})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // The outstanding request always corresponds to the FIFO head, which is
    // only popped on the transfer. A new request therefore sources entry 0
    // when nothing is outstanding, or entry 1 when the current one completes.
    // If that entry is being pushed this very cycle, pix_data is forwarded so
    // a pixel into an empty FIFO is requested on the next cycle.
    assign w_slot_free   = !r_req || w_xfer;
    assign w_sel         = r_req;
    assign w_src_in_fifo = (r_count > {{c_PTR_W{1'b0}}, w_sel});
    assign w_rd_idx      = r_rd_ptr + {{(c_PTR_W-1){1'b0}}, w_sel};
    assign w_load        = w_slot_free && ram_rdy && (w_src_in_fifo || w_push);
    assign w_load_pix    = w_src_in_fifo ? r_mem[w_rd_idx] : pix_data;
    assign w_req_next    = w_load || (r_req && !w_xfer);
    assign w_in_cnt_inc  = r_in_cnt + 29'd1;

    // DRAIN exit looks at next-cycle FIFO/request state so frame_done and
    // the fall of busy land on the cycle right after the final transfer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start)
                    w_state_next = c_CAPTURE;
            end
            c_CAPTURE: begin
                if (w_pix_in && (w_in_cnt_inc == c_FRAME))
                    w_state_next = c_DRAIN;
            end
            c_DRAIN: begin
                if ((w_count_next == '0) && !w_req_next)
                    w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: contents qualified by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= pix_data;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_in_cnt     <= '0;
            r_req        <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_wdata      <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_req   <= w_req_next;

            if (w_push)
                r_wr_ptr <= r_wr_ptr + {{(c_PTR_W-1){1'b0}}, 1'b1};
            if (w_xfer)
                r_rd_ptr <= r_rd_ptr + {{(c_PTR_W-1){1'b0}}, 1'b1};

            if (w_load)
                r_wdata <= {8'h00, w_load_pix};

            // r_addr tracks the address of the head pixel; it only moves on
            // a completed transfer, so dropped pixels never consume one.
            if (w_start) begin
                r_addr     <= BASE_ADDR;
                r_in_cnt   <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_xfer)
                    r_addr <= r_addr + 29'd1;
                if (w_pix_in)
                    r_in_cnt <= w_in_cnt_inc;
                if (w_drop)
                    r_overflow <= 1'b1;
            end

            if (frame_start && (r_state != c_IDLE))
                r_sync_err <= 1'b1;

            r_frame_done <= (r_state == c_DRAIN) && (w_state_next == c_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign avl_write_req = r_req;
    assign avl_addr      = r_addr;
    assign wr_data       = r_wdata;
    assign busy          = (r_state != c_IDLE);
    assign frame_done    = r_frame_done;
    assign overflow      = r_overflow;
    assign sync_err      = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_pix_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pix_wr_ctrl
//  Description : Scoreboard bench for pix_wr_ctrl. Instance A: 4-pixel frames,
//                16-entry FIFO. Instance B: 8-pixel frames, 4-entry FIFO for
//                the overflow scenario. Stimulus pushes expected writes into
//                per-instance queues; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pix_wr_ctrl;

    localparam logic [28:0] c_BASE = 29'h100;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A
    logic        a_frame_start = 1'b0, a_pix_valid = 1'b0, a_ram_rdy = 1'b1, a_ready = 1'b1;
    logic [23:0] a_pix_data = '0;
    logic        a_req, a_busy, a_done, a_ovf, a_serr;
    logic [28:0] a_addr;
    logic [31:0] a_wdata;
    // Instance B
    logic        b_frame_start = 1'b0, b_pix_valid = 1'b0, b_ram_rdy = 1'b1, b_ready = 1'b0;
    logic [23:0] b_pix_data = '0;
    logic        b_req, b_busy, b_done, b_ovf, b_serr;
    logic [28:0] b_addr;
    logic [31:0] b_wdata;

    pix_wr_ctrl #(.FRAME_PIXELS(4), .BASE_ADDR(c_BASE), .FIFO_DEPTH(16)) u_dut_a (
        .clk(clk), .reset(reset), .frame_start(a_frame_start), .pix_valid(a_pix_valid),
        .pix_data(a_pix_data), .ram_rdy(a_ram_rdy), .avl_ready(a_ready),
        .avl_write_req(a_req), .avl_addr(a_addr), .wr_data(a_wdata), .busy(a_busy),
        .frame_done(a_done), .overflow(a_ovf), .sync_err(a_serr));

    pix_wr_ctrl #(.FRAME_PIXELS(8), .BASE_ADDR(c_BASE), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .reset(reset), .frame_start(b_frame_start), .pix_valid(b_pix_valid),
        .pix_data(b_pix_data), .ram_rdy(b_ram_rdy), .avl_ready(b_ready),
        .avl_write_req(b_req), .avl_addr(b_addr), .wr_data(b_wdata), .busy(b_busy),
        .frame_done(b_done), .overflow(b_ovf), .sync_err(b_serr));

    int n_checks = 0;
    int n_fail   = 0;

    logic [60:0] exp_a[$];
    logic [60:0] exp_b[$];
    int          a_hold_hist[$];

    int neg_cyc = 0;
    int a_hold = 0, a_last_xfer = 0, a_done_cnt = 0, a_xfer_cnt = 0;
    int b_last_xfer = 0, b_done_cnt = 0, b_xfer_cnt = 0;
    bit a_done_prev = 1'b0, b_done_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: every cycle a request is presented it must match the queue
    // head; the head is retired on the transfer cycle.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        neg_cyc++;
        if (reset) begin
            a_hold      = 0;
            a_done_prev = 1'b0;
            b_done_prev = 1'b0;
        end else begin
            if (a_req) begin
                if (exp_a.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL a_unexpected_write: got addr %0h data %0h, expected no write", a_addr, a_wdata);
                end else begin
                    check("a_write", {a_addr, a_wdata}, exp_a[0]);
                    a_hold++;
                    if (a_ready) begin
                        void'(exp_a.pop_front());
                        a_hold_hist.push_back(a_hold);
                        a_hold      = 0;
                        a_last_xfer = neg_cyc;
                        a_xfer_cnt++;
                    end
                end
            end
            if (a_done) begin
                check("a_done_latency", neg_cyc, a_last_xfer + 1);
                check("a_done_busy", a_busy, 1'b0);
                check("a_done_width", a_done_prev, 1'b0);
                a_done_cnt++;
            end
            a_done_prev = a_done;

            if (b_req) begin
                if (exp_b.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL b_unexpected_write: got addr %0h data %0h, expected no write", b_addr, b_wdata);
                end else begin
                    check("b_write", {b_addr, b_wdata}, exp_b[0]);
                    if (b_ready) begin
                        void'(exp_b.pop_front());
                        b_last_xfer = neg_cyc;
                        b_xfer_cnt++;
                    end
                end
            end
            if (b_done) begin
                check("b_done_latency", neg_cyc, b_last_xfer + 1);
                check("b_done_busy", b_busy, 1'b0);
                check("b_done_width", b_done_prev, 1'b0);
                b_done_cnt++;
            end
            b_done_prev = b_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 4-pixel frame on A. rdy_pat bit k is avl_ready in the k-th cycle
    // after frame_start; sync_at >= 0 adds a stray frame_start in that cycle.
    task automatic a_run(input logic [31:0] rdy_pat, input int ncyc, input int sync_at,
                         input logic [23:0] pix0, input logic rdy_after);
        a_frame_start = 1'b1;
        tick();
        for (int k = 0; k < ncyc; k++) begin
            a_ready       = rdy_pat[k];
            a_frame_start = (k == sync_at);
            if (k < 4) begin
                a_pix_valid = 1'b1;
                a_pix_data  = pix0 + 24'(k) * 24'h111111;
                exp_a.push_back({c_BASE + 29'(k), 8'h00, a_pix_data});
            end else begin
                a_pix_valid = 1'b0;
            end
            tick();
        end
        a_pix_valid   = 1'b0;
        a_frame_start = 1'b0;
        a_ready       = rdy_after;
    endtask

    task automatic wait_done(input bit is_b, input int start_cnt);
        int n;
        n = 0;
        while (((is_b ? b_done_cnt : a_done_cnt) == start_cnt) && (n < 100)) begin
            tick();
            n++;
        end
        check(is_b ? "b_done_seen" : "a_done_seen", n < 100, 1'b1);
    endtask

    initial begin
        int cnt0, x0;

        repeat (3) tick();
        reset = 1'b0;
        // Reset state
        check("rst_req",   a_req,   1'b0);
        check("rst_addr",  a_addr,  c_BASE);
        check("rst_data",  a_wdata, 32'h0);
        check("rst_busy",  a_busy,  1'b0);
        check("rst_done",  a_done,  1'b0);
        check("rst_ovf",   a_ovf,   1'b0);
        check("rst_serr",  a_serr,  1'b0);
        tick();

        // 1: back-to-back frame with avl_ready tied high
        cnt0 = a_done_cnt; x0 = a_xfer_cnt;
        a_run(32'hFFFF_FFFF, 4, -1, 24'h111111, 1'b1);
        wait_done(1'b0, cnt0);
        check("t1_xfers",  a_xfer_cnt - x0, 4);
        check("t1_queue",  exp_a.size(), 0);
        check("t1_ovf",    a_ovf, 1'b0);
        check("t1_busy",   a_busy, 1'b0);
        tick();

        // 2: avl_ready low for 5 cycles while the 2nd request is pending
        a_hold_hist.delete();
        cnt0 = a_done_cnt; x0 = a_xfer_cnt;
        a_run(32'hFFFF_FF83, 8, -1, 24'h111111, 1'b1);
        wait_done(1'b0, cnt0);
        check("t2_xfers",  a_xfer_cnt - x0, 4);
        check("t2_queue",  exp_a.size(), 0);
        check("t2_hold",   a_hold_hist[1], 6);
        check("t2_serr",   a_serr, 1'b0);
        tick();

        // 4: stray frame_start during CAPTURE
        cnt0 = a_done_cnt; x0 = a_xfer_cnt;
        a_run(32'hFFFF_FFFF, 4, 2, 24'h0A0B0C, 1'b1);
        wait_done(1'b0, cnt0);
        check("t4_serr",   a_serr, 1'b1);
        check("t4_xfers",  a_xfer_cnt - x0, 4);
        check("t4_queue",  exp_a.size(), 0);
        tick();

        // 5: reset while a request to BASE+2 is pending
        a_run(32'h0000_0030, 8, -1, 24'h123456, 1'b0);
        check("t5_pending_req",  a_req,  1'b1);
        check("t5_pending_addr", a_addr, c_BASE + 29'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_req",  a_req,  1'b0);
        check("t5_addr", a_addr, c_BASE);
        check("t5_busy", a_busy, 1'b0);
        check("t5_serr", a_serr, 1'b0);
        exp_a.delete();
        a_ready = 1'b1;
        tick();
        cnt0 = a_done_cnt;
        a_run(32'hFFFF_FFFF, 4, -1, 24'h202020, 1'b1);
        wait_done(1'b0, cnt0);
        check("t5_queue", exp_a.size(), 0);
        tick();

        // 6: frame_start ignored while the memory is not ready
        a_ram_rdy     = 1'b0;
        a_frame_start = 1'b1;
        tick();
        a_frame_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_pix_valid = 1'b1;
            a_pix_data  = 24'hDEAD00 + 24'(k);
            tick();
            check("t6_busy", a_busy, 1'b0);
        end
        a_pix_valid = 1'b0;
        tick();
        check("t6_req", a_req, 1'b0);
        a_ram_rdy = 1'b1;
        cnt0 = a_done_cnt; x0 = a_xfer_cnt;
        a_run(32'hFFFF_FFFF, 4, -1, 24'h010203, 1'b1);
        wait_done(1'b0, cnt0);
        check("t6_xfers", a_xfer_cnt - x0, 4);
        check("t6_queue", exp_a.size(), 0);
        tick();

        // 3: 8 pixels into a 4-deep FIFO with avl_ready held low
        b_ready       = 1'b0;
        b_frame_start = 1'b1;
        tick();
        b_frame_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            b_pix_valid = 1'b1;
            b_pix_data  = 24'hA00001 + 24'(k);
            if (k < 4)
                exp_b.push_back({c_BASE + 29'(k), 8'h00, b_pix_data});
            tick();
        end
        b_pix_valid = 1'b0;
        check("t3_ovf_set", b_ovf,  1'b1);
        check("t3_busy",    b_busy, 1'b1);
        cnt0 = b_done_cnt;
        b_ready = 1'b1;
        wait_done(1'b1, cnt0);
        check("t3_xfers",    b_xfer_cnt, 4);
        check("t3_queue",    exp_b.size(), 0);
        check("t3_ovf_kept", b_ovf,  1'b1);
        check("t3_busy_end", b_busy, 1'b0);
        repeat (3) tick();
        check("t3_no_more",  b_xfer_cnt, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
